// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and MEM masters onto one 8-bit RAM port,
// splitting accesses into byte transfers and reassembling read data little-endian.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    input  logic                  if_flush_i,
    output logic                  if_done_o,
    output logic [DATA_WIDTH-1:0] if_data_o,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [1:0]            mem_len_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i,
    output logic                  mem_done_o,
    output logic [DATA_WIDTH-1:0] mem_rdata_o,
    input  logic [7:0]            ram_din_i,
    output logic [7:0]            ram_dout_o,
    output logic [ADDR_WIDTH-1:0] ram_a_o,
    output logic                  ram_wr_o
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ramAddr_q, ramAddr_d;
    logic [2:0]            numBytes_q, numBytes_d;
    logic [2:0]            byteCnt_q, byteCnt_d;
    logic                  ownerIf_q, ownerIf_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] capture_q, capture_d;
    logic [DATA_WIDTH-1:0] ifData_q, ifData_d;
    logic [DATA_WIDTH-1:0] memData_q, memData_d;
    logic [1:0]            lane;

    assign lane = byteCnt_q[1:0] - 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ramAddr_q  <= '0;
            numBytes_q <= '0;
            byteCnt_q  <= '0;
            ownerIf_q  <= 1'b0;
            wdata_q    <= '0;
            capture_q  <= '0;
            ifData_q   <= '0;
            memData_q  <= '0;
        end else begin
            state_q    <= state_d;
            ramAddr_q  <= ramAddr_d;
            numBytes_q <= numBytes_d;
            byteCnt_q  <= byteCnt_d;
            ownerIf_q  <= ownerIf_d;
            wdata_q    <= wdata_d;
            capture_q  <= capture_d;
            ifData_q   <= ifData_d;
            memData_q  <= memData_d;
        end
    end

    // ramAddr_q doubles as the running byte address; it stops on the last byte so it holds afterwards.
    always_comb begin
        state_d    = state_q;
        ramAddr_d  = ramAddr_q;
        numBytes_d = numBytes_q;
        byteCnt_d  = byteCnt_q;
        ownerIf_d  = ownerIf_q;
        wdata_d    = wdata_q;
        capture_d  = capture_q;
        ifData_d   = ifData_q;
        memData_d  = memData_q;
        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    ramAddr_d = mem_addr_i;
                    ownerIf_d = 1'b0;
                    wdata_d   = mem_wdata_i;
                    capture_d = '0;
                    byteCnt_d = '0;
                    case (mem_len_i)
                        2'b00:   numBytes_d = 3'd1;
                        2'b01:   numBytes_d = 3'd2;
                        default: numBytes_d = 3'd4;
                    endcase
                    state_d = mem_we_i ? WRITE : READ;
                end else if (if_req_i && !if_flush_i) begin
                    ramAddr_d  = if_addr_i;
                    ownerIf_d  = 1'b1;
                    wdata_d    = '0;
                    capture_d  = '0;
                    byteCnt_d  = '0;
                    numBytes_d = 3'd4;
                    state_d    = READ;
                end
            end
            READ: begin
                if (ownerIf_q && if_flush_i) begin
                    state_d   = IDLE;
                    capture_d = '0;
                    byteCnt_d = '0;
                end else begin
                    if (byteCnt_q != 3'd0) begin
                        capture_d[{lane, 3'b000} +: 8] = ram_din_i;
                    end
                    if (byteCnt_q == numBytes_q) begin
                        state_d = DONE;
                        if (ownerIf_q) begin
                            ifData_d = capture_d;
                        end else begin
                            memData_d = capture_d;
                        end
                    end else begin
                        byteCnt_d = byteCnt_q + 3'd1;
                        if (byteCnt_q + 3'd1 < numBytes_q) begin
                            ramAddr_d = ramAddr_q + ADDR_WIDTH'(1);
                        end
                    end
                end
            end
            WRITE: begin
                if (byteCnt_q == numBytes_q - 3'd1) begin
                    state_d   = DONE;
                    memData_d = capture_q;
                end else begin
                    byteCnt_d = byteCnt_q + 3'd1;
                    ramAddr_d = ramAddr_q + ADDR_WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ram_a_o     = ramAddr_q;
    assign ram_wr_o    = (state_q == WRITE);
    assign ram_dout_o  = (state_q == WRITE) ? wdata_q[{byteCnt_q[1:0], 3'b000} +: 8] : 8'h00;
    assign if_done_o   = (state_q == DONE) && ownerIf_q;
    assign mem_done_o  = (state_q == DONE) && !ownerIf_q;
    assign if_data_o   = ifData_q;
    assign mem_rdata_o = memData_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed scenarios plus random traffic against a byte-map
// reference model; a negedge monitor pops expected completions and RAM writes.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_flush_i = 1'b0;
    logic        if_done_o;
    logic [31:0] if_data_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [1:0]  mem_len_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic [7:0]  ram_din_i = '0;
    logic [7:0]  ram_dout_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;

    int tests = 0;
    int failures = 0;

    typedef struct {logic isLoad; logic [31:0] data;} memExp_t;
    typedef struct {logic [31:0] a; logic [7:0] d;} wrExp_t;

    logic [31:0] ifQ[$];
    memExp_t     memQ[$];
    wrExp_t      wrQ[$];
    memExp_t     me;
    wrExp_t      we;

    logic [7:0] ramMem[logic [31:0]];
    logic [7:0] refMem[logic [31:0]];

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_done_o(if_done_o), .if_data_o(if_data_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
        .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o), .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o)
    );

    function automatic logic [7:0] initByte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ramRd(input logic [31:0] a);
        return ramMem.exists(a) ? ramMem[a] : initByte(a);
    endfunction

    function automatic logic [7:0] refRd(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : initByte(a);
    endfunction

    function automatic int nBytes(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] addr, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(refRd(addr + 32'(i))) << (8 * i));
        return v;
    endfunction

    // RAM device: one-cycle read latency, writes land at the edge ending a write cycle
    always @(posedge clk) begin
        if (ram_wr_o) ramMem[ram_a_o] = ram_dout_o;
        ram_din_i <= ramRd(ram_a_o);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic setByte(input logic [31:0] a, input logic [7:0] d);
        ramMem[a] = d;
        refMem[a] = d;
    endtask

    task automatic refStore(input logic [31:0] addr, input int n, input logic [31:0] wdata);
        wrExp_t w;
        for (int i = 0; i < n; i++) begin
            w.a = addr + 32'(i);
            w.d = wdata[8*i +: 8];
            refMem[w.a] = w.d;
            wrQ.push_back(w);
        end
    endtask

    // Completion and RAM-write monitor
    always @(negedge clk) begin
        if (rst) begin
            if (mem_done_o) begin
                if (memQ.size() == 0) begin
                    tests++; failures++;
                    $display("[TB] FAIL mem_done_unexpected: got 1, expected 0");
                end else begin
                    me = memQ.pop_front();
                    if (me.isLoad) checkOutput("mem_rdata", mem_rdata_o, me.data);
                end
            end
            if (if_done_o) begin
                if (ifQ.size() == 0) begin
                    tests++; failures++;
                    $display("[TB] FAIL if_done_unexpected: got 1, expected 0");
                end else begin
                    checkOutput("if_data", if_data_o, ifQ.pop_front());
                end
            end
            if (ram_wr_o) begin
                if (wrQ.size() == 0) begin
                    tests++; failures++;
                    $display("[TB] FAIL ram_wr_unexpected: got addr 0x%08h, expected no write", ram_a_o);
                end else begin
                    we = wrQ.pop_front();
                    checkOutput("ram_a_wr", ram_a_o, we.a);
                    checkOutput("ram_dout", 32'(ram_dout_o), 32'(we.d));
                end
            end
        end
    end

    // One transaction from a single master; returns in an IDLE cycle at a negedge.
    task automatic applyStimulus(input bit isIf, input bit wr, input logic [1:0] len,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int flushCycle);
        int n = isIf ? 4 : nBytes(len);
        int edges = 0;
        int expLat = (!isIf && wr) ? n + 1 : n + 2;
        bit seen = 0;
        bit flushed = 0;
        memExp_t e;
        if (isIf) begin
            if (flushCycle < 0) ifQ.push_back(refLoad(addr, 4));
            if_addr_i = addr;
            if_req_i  = 1'b1;
        end else begin
            e.isLoad = !wr;
            e.data   = wr ? 32'h0 : refLoad(addr, n);
            if (wr) refStore(addr, n, wdata);
            memQ.push_back(e);
            mem_we_i    = wr;
            mem_len_i   = len;
            mem_addr_i  = addr;
            mem_wdata_i = wdata;
            mem_req_i   = 1'b1;
        end
        while (!seen && !flushed && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (isIf && flushCycle >= 0 && edges - 1 == flushCycle) begin
                if_flush_i = 1'b1;
                if_req_i   = 1'b0;
                @(negedge clk);
                if_flush_i = 1'b0;
                flushed    = 1;
            end else begin
                seen = isIf ? if_done_o : mem_done_o;
            end
        end
        if (!flushed) begin
            if (!seen) begin
                tests++; failures++;
                $display("[TB] FAIL done_timeout: got no done in %0d cycles, expected done", edges);
            end else begin
                checkOutput("latency", 32'(edges), 32'(expLat));
            end
            if_req_i  = 1'b0;
            mem_req_i = 1'b0;
            @(negedge clk);
        end
    endtask

    // Simultaneous byte load and fetch: MEM first, IF accepted at the first IDLE edge after DONE
    task automatic applyBoth(input logic [31:0] memAddr, input logic [31:0] ifAddr);
        int edges = 0;
        memExp_t e;
        e.isLoad = 1;
        e.data   = refLoad(memAddr, 1);
        memQ.push_back(e);
        ifQ.push_back(refLoad(ifAddr, 4));
        mem_we_i = 1'b0; mem_len_i = 2'b00; mem_addr_i = memAddr; mem_req_i = 1'b1;
        if_addr_i = ifAddr; if_req_i = 1'b1;
        while (!mem_done_o && edges < 40) begin
            @(posedge clk); edges++; @(negedge clk);
            checkOutput("if_not_first", 32'(if_done_o), 32'h0);
        end
        checkOutput("both_mem_latency", 32'(edges), 32'd3);
        mem_req_i = 1'b0;
        edges = 0;
        while (!if_done_o && edges < 40) begin
            @(posedge clk); edges++; @(negedge clk);
        end
        checkOutput("both_if_latency", 32'(edges), 32'd7);
        if_req_i = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] pickAddr();
        if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        return 32'($urandom_range(0, 63));
    endfunction

    initial begin
        logic [31:0] a;
        #2 rst = 1'b0;
        #1;
        checkOutput("reset_ram_a", ram_a_o, 32'h0);
        checkOutput("reset_ram_wr", 32'(ram_wr_o), 32'h0);
        checkOutput("reset_ram_dout", 32'(ram_dout_o), 32'h0);
        checkOutput("reset_dones", {30'h0, if_done_o, mem_done_o}, 32'h0);
        checkOutput("reset_if_data", if_data_o, 32'h0);
        checkOutput("reset_mem_rdata", mem_rdata_o, 32'h0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        setByte(32'h10, 8'h13); setByte(32'h11, 8'h05);
        setByte(32'h12, 8'h10); setByte(32'h13, 8'h00);
        checkOutput("plan_fetch_model", refLoad(32'h10, 4), 32'h0010_0513);
        applyStimulus(1, 0, 2'b11, 32'h10, 32'h0, -1);

        setByte(32'h20, 8'hAB);
        applyBoth(32'h20, 32'h10);

        applyStimulus(0, 1, 2'b11, 32'h100, 32'hDEAD_BEEF, -1);
        checkOutput("ram_wr_after_store", 32'(ram_wr_o), 32'h0);

        applyStimulus(1, 0, 2'b11, 32'h10, 32'h0, 2);
        applyStimulus(0, 0, 2'b00, 32'h20, 32'h0, -1);

        setByte(32'hFFFF_FFFF, 8'h34); setByte(32'h0, 8'h12);
        checkOutput("plan_wrap_model", refLoad(32'hFFFF_FFFF, 2), 32'h0000_1234);
        applyStimulus(0, 0, 2'b01, 32'hFFFF_FFFF, 32'h0, -1);

        // Reset during cycle 2 of a word store: bytes 0 and 1 have landed, byte 2 is dropped
        begin
            wrExp_t w;
            for (int i = 0; i < 3; i++) begin
                w.a = 32'h200 + 32'(i);
                w.d = 8'(32'hCAFE_F00D >> (8 * i));
                wrQ.push_back(w);
                if (i < 2) refMem[w.a] = w.d;
            end
            mem_we_i = 1'b1; mem_len_i = 2'b11; mem_addr_i = 32'h200;
            mem_wdata_i = 32'hCAFE_F00D; mem_req_i = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); @(negedge clk);
            end
            #2 rst = 1'b0;
            mem_req_i = 1'b0;
            #1;
            checkOutput("midrst_ram_wr", 32'(ram_wr_o), 32'h0);
            checkOutput("midrst_ram_a", ram_a_o, 32'h0);
            checkOutput("midrst_dones", {30'h0, if_done_o, mem_done_o}, 32'h0);
            @(negedge clk); rst = 1'b1;
            @(negedge clk);
            applyStimulus(0, 0, 2'b11, 32'h200, 32'h0, -1);
        end

        for (int k = 0; k < 40; k++) begin
            a = pickAddr();
            case ($urandom_range(0, 4))
                0: applyStimulus(1, 0, 2'b11, a, 32'h0, -1);
                1: applyStimulus(0, 0, 2'($urandom_range(0, 3)), a, 32'h0, -1);
                2: applyStimulus(0, 1, 2'($urandom_range(0, 3)), a, $urandom, -1);
                3: applyStimulus(1, 0, 2'b11, a, 32'h0, $urandom_range(0, 4));
                default: applyBoth(a, pickAddr());
            endcase
        end

        repeat (3) @(negedge clk);
        checkOutput("if_queue_drained", 32'(ifQ.size()), 32'h0);
        checkOutput("mem_queue_drained", 32'(memQ.size()), 32'h0);
        checkOutput("wr_queue_drained", 32'(wrQ.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller between the instruction-fetch stage, the MEM stage and the single 8-bit-wide RAM/IO port.
- Arbitrates between the two masters; MEM has priority.
- Splits word, halfword and byte accesses into consecutive byte transfers and reassembles read data little-endian.
- Returns a one-cycle done pulse with the result to the master that was served.

Parameters:
- ADDR_WIDTH, 32, width of byte addresses.
- DATA_WIDTH, 32, width of master data buses.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request; held until if_done_o
- if_addr_i  in  ADDR_WIDTH  fetch address (always a 4-byte read)
- if_flush_i  in  1  abort in-flight fetch (branch redirect)
- if_done_o  out  1  one-cycle fetch completion pulse
- if_data_o  out  DATA_WIDTH  fetched word, valid while if_done_o=1
- mem_req_i  in  1  load/store request; held until mem_done_o
- mem_we_i  in  1  1=store, 0=load
- mem_len_i  in  2  00=byte, 01=half, 11=word; 10 is treated as word
- mem_addr_i  in  ADDR_WIDTH  base byte address
- mem_wdata_i  in  DATA_WIDTH  store data; low bytes are used first
- mem_done_o  out  1  one-cycle completion pulse
- mem_rdata_o  out  DATA_WIDTH  load data, zero-extended, valid while mem_done_o=1
- ram_din_i  in  8  RAM read byte
- ram_dout_o  out  8  RAM write byte
- ram_a_o  out  ADDR_WIDTH  RAM byte address
- ram_wr_o  out  1  1=write, 0=read

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs are 0, including ram_a_o, ram_wr_o, ram_dout_o, both done pulses and both data outputs. Byte counter and capture registers are cleared.
- RAM timing: the byte addressed on ram_a_o in cycle c appears on ram_din_i in cycle c+1.
- States: IDLE, READ, WRITE, DONE. N = bytes in the access: 1, 2 or 4; IF always 4.
- IDLE arbitration, at each edge:
  - mem_req_i=1: accept MEM.
  - otherwise if_req_i=1 and if_flush_i=0: accept IF.
  - otherwise stay in IDLE.
  - Simultaneous requests: MEM wins; the IF request waits.
- Latch on acceptance: base address, N, we, wdata and owner.
- Cycle numbering: cycle 0 is the first cycle after the acceptance edge.
- READ:
  - Cycle i (0..N-1): ram_a_o = base+i, ram_wr_o=0.
  - ram_din_i is captured into byte lane i-1 at the end of cycles 1..N.
  - Enter DONE after cycle N. DONE occupies cycle N+1, so a word read completes in cycle 5.
- WRITE:
  - Cycle i (0..N-1): ram_a_o = base+i, ram_dout_o = wdata[8i+7:8i], ram_wr_o=1.
  - Enter DONE after cycle N-1. DONE occupies cycle N, so a word write completes in cycle 4.
- DONE:
  - Exactly one cycle. The owner's done_o is 1 and its data output carries the assembled value; upper unused bytes are 0.
  - No request is accepted in DONE. The next state is IDLE, which gives masters one cycle to drop req.
- Outside DONE: the done outputs are 0; data outputs hold their last value.
- Outside READ/WRITE: ram_wr_o=0 and ram_dout_o=0; ram_a_o holds its last value.
- Address arithmetic is modulo 2^ADDR_WIDTH; base+i wraps past all-ones to 0.
- if_flush_i=1 while IF owns READ: at the next edge go to IDLE with no if_done_o pulse, and discard captured bytes.
- if_flush_i has no effect on a MEM-owned transfer or on DONE. A flush in DONE still delivers the pulse; the IF stage must ignore it.
- Master request changes mid-transfer are ignored; latched values govern the transfer.
- Reset asserted mid-transfer: immediate return to reset values with ram_wr_o=0 combinationally from the reset flop state. The partial write is not completed.

Test Plan:
- IF read at 0x00000010, RAM bytes 13,05,10,00 -> ram_a_o 0x10..0x13 in cycles 0-3; if_done_o=1 only in cycle 5; if_data_o=0x00100513.
- if_req_i and mem_req_i (load, len=00, addr 0x20, RAM byte 0xAB) rise in the same cycle -> MEM served first; mem_done_o in cycle 2 with mem_rdata_o=0x000000AB; IF is accepted at the first IDLE edge after DONE.
- Store word 0xDEADBEEF to 0x100 -> cycles 0-3 have ram_wr_o=1 with (0x100,EF),(0x101,BE),(0x102,AD),(0x103,DE); mem_done_o in cycle 4; ram_wr_o=0 afterward.
- IF read, if_flush_i=1 in cycle 2 -> no if_done_o; IDLE next cycle; a pending mem_req_i is accepted at the following edge.
- Halfword load at 0xFFFFFFFF, RAM[0xFFFFFFFF]=0x34, RAM[0]=0x12 -> ram_a_o = 0xFFFFFFFF then 0x00000000; mem_rdata_o=0x00001234.
- rst=0 during cycle 2 of a word store -> ram_wr_o, ram_a_o and all done outputs go to 0 before the next edge; after release, IDLE accepts new requests.
